serial_link_lanes: RTL and testbench

//  Parametrised serial link endpoint for the NoC: a TX half serialises {padding,packet} over LANES wires.
//  An RX half deserialises it back; both halves live in one module, with line ports exposed so they can be split across routers.

---
 rtl/serial_link_lanes.sv | 152 +++++++++++++++
 tb/tb_serial_link_lanes.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_lanes.sv
// Serial link endpoint: TX serialises {padding,packet} over LANES wires with an optional
// even-parity beat; RX deserialises it, checks parity and holds the frame until flushed.
module serial_link_lanes #(
    parameter int DATA_W    = 42,
    parameter int PAD_W     = 4,
    parameter int LANES     = 1,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sender_enable,
    input  logic [PAD_W-1:0]  sender_padding,
    input  logic [DATA_W-1:0] sender_packet,
    output logic              sender_ack,
    output logic              ser_valid_out,
    output logic [LANES-1:0]  ser_data_out,
    input  logic              ser_ready_in,
    input  logic              ser_valid_in,
    input  logic [LANES-1:0]  ser_data_in,
    output logic              ser_ready_out,
    input  logic              receiver_flush,
    output logic              receiver_valid,
    output logic [PAD_W-1:0]  receiver_padding,
    output logic [DATA_W-1:0] receiver_packet,
    output logic              receiver_error
);
    // state    | meaning
    // TX_IDLE  | waiting for sender_enable with far RX ready
    // TX_SEND  | driving BEATS consecutive beats on the line
    // TX_DONE  | sender_ack high until sender_enable drops
    // RX_IDLE  | no frame in progress
    // RX_RECV  | collecting beats, gaps stall the count
    // RX_CHECK | all beats in, parity evaluated
    // RX_HOLD  | frame presented until receiver_flush

    localparam int W       = PAD_W + DATA_W;
    localparam int DBEATS  = (W + LANES - 1) / LANES;
    localparam int BEATS   = DBEATS + PARITY_EN;
    localparam int CNT_W   = $clog2(BEATS + 1);
    localparam int TX_W    = DBEATS * LANES;
    localparam int RX_W    = BEATS * LANES;
    localparam int PAR_BIT = (PARITY_EN != 0) ? DBEATS * LANES : 0;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] PAR_BEAT  = CNT_W'(DBEATS);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_CHECK, RX_HOLD} rx_state_t;

    tx_state_t         tx_state, tx_next;
    logic [TX_W-1:0]   tx_shift;
    logic              tx_par;
    logic [CNT_W-1:0]  tx_cnt;
    logic              tx_latch;

    rx_state_t         rx_state, rx_next;
    logic [RX_W-1:0]   rx_shift;
    logic [CNT_W-1:0]  rx_cnt;
    logic              rx_take;
    logic              parity_ok;
    logic              rx_unused;

    always_comb begin
        tx_next       = tx_state;
        tx_latch      = 1'b0;
        ser_valid_out = 1'b0;
        ser_data_out  = '0;
        sender_ack    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (sender_enable && ser_ready_in) begin
                    tx_latch = 1'b1;
                    tx_next  = TX_SEND;
                end
            end
            TX_SEND: begin
                ser_valid_out = 1'b1;
                // PAR_BEAT is never reached when there is no parity beat
                if (tx_cnt == PAR_BEAT) ser_data_out = LANES'(tx_par);
                else                    ser_data_out = tx_shift[LANES-1:0];
                if (tx_cnt == LAST_BEAT) tx_next = TX_DONE;
            end
            TX_DONE: begin
                sender_ack = 1'b1;
                if (!sender_enable) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_cnt   <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_latch) begin
                tx_shift <= TX_W'({sender_padding, sender_packet});
                tx_par   <= ^{sender_padding, sender_packet};
                tx_cnt   <= '0;
            end else if (tx_state == TX_SEND) begin
                tx_shift <= tx_shift >> LANES;
                tx_cnt   <= tx_cnt + 1'b1;
            end
        end
    end

    // Fill bits and the upper bits of the parity beat are received but never used
    assign rx_unused = ^rx_shift;
    assign parity_ok = (PARITY_EN == 0) || ((^rx_shift[W-1:0]) == rx_shift[PAR_BIT]);

    always_comb begin
        rx_next        = rx_state;
        rx_take        = 1'b0;
        ser_ready_out  = (rx_state != RX_HOLD);
        receiver_valid = (rx_state == RX_HOLD);
        case (rx_state)
            RX_IDLE, RX_RECV: begin
                if (ser_valid_in) begin
                    rx_take = 1'b1;
                    rx_next = (rx_cnt == LAST_BEAT) ? RX_CHECK : RX_RECV;
                end
            end
            RX_CHECK: rx_next = parity_ok ? RX_HOLD : RX_IDLE;
            RX_HOLD:  if (receiver_flush) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state         <= RX_IDLE;
            rx_shift         <= '0;
            rx_cnt           <= '0;
            receiver_padding <= '0;
            receiver_packet  <= '0;
            receiver_error   <= 1'b0;
        end else begin
            rx_state       <= rx_next;
            receiver_error <= (rx_state == RX_CHECK) && !parity_ok;
            if (rx_take) begin
                rx_shift <= (rx_shift >> LANES) | (RX_W'(ser_data_in) << (RX_W - LANES));
                rx_cnt   <= rx_cnt + 1'b1;
            end
            if (rx_state == RX_CHECK) begin
                rx_cnt <= '0;
                if (parity_ok) {receiver_padding, receiver_packet} <= rx_shift[W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_serial_link_lanes.sv
// Directed loopback bench for serial_link_lanes at LANES=1, 4 and 8.
module tb_serial_link_lanes;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0]  PAD_A = 4'b1011;
    localparam logic [41:0] PKT_A = 42'h2AC19440329;
    localparam logic [3:0]  PAD_B = 4'h9;
    localparam logic [41:0] PKT_B = 42'h123456789AB;
    localparam logic [3:0]  PAD_C = 4'b0110;
    localparam logic [41:0] PKT_C = 42'h3FF00000001;

    // LANES=1 instance, loopback with optional bit flip or bench-driven RX
    logic        en1, ack1, vo1, do1, vi1, di1, ro1, flush1, rv1, re1;
    logic [3:0]  pad1, rp1;
    logic [41:0] pkt1, rk1;
    logic        drv, drv_valid, drv_data, flip_en;
    int          idx1 = 0;

    assign vi1 = drv ? drv_valid : vo1;
    assign di1 = drv ? drv_data : (do1 ^ (flip_en && idx1 == 5));
    always @(posedge clk) idx1 <= vo1 ? idx1 + 1 : 0;

    serial_link_lanes #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .sender_enable(en1), .sender_padding(pad1), .sender_packet(pkt1),
        .sender_ack(ack1), .ser_valid_out(vo1), .ser_data_out(do1), .ser_ready_in(ro1),
        .ser_valid_in(vi1), .ser_data_in(di1), .ser_ready_out(ro1), .receiver_flush(flush1),
        .receiver_valid(rv1), .receiver_padding(rp1), .receiver_packet(rk1), .receiver_error(re1)
    );

    // LANES=4 and LANES=8 instances share stimulus, plain loopback
    logic        en48, flush48;
    logic [3:0]  pad48;
    logic [41:0] pkt48;
    logic        ack4, vo4, ro4, rv4, re4, ack8, vo8, ro8, rv8, re8;
    logic [3:0]  do4, rp4, rp8;
    logic [7:0]  do8;
    logic [41:0] rk4, rk8;

    serial_link_lanes #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .sender_enable(en48), .sender_padding(pad48), .sender_packet(pkt48),
        .sender_ack(ack4), .ser_valid_out(vo4), .ser_data_out(do4), .ser_ready_in(ro4),
        .ser_valid_in(vo4), .ser_data_in(do4), .ser_ready_out(ro4), .receiver_flush(flush48),
        .receiver_valid(rv4), .receiver_padding(rp4), .receiver_packet(rk4), .receiver_error(re4)
    );

    serial_link_lanes #(.LANES(8)) u_l8 (
        .clk(clk), .rst(rst), .sender_enable(en48), .sender_padding(pad48), .sender_packet(pkt48),
        .sender_ack(ack8), .ser_valid_out(vo8), .ser_data_out(do8), .ser_ready_in(ro8),
        .ser_valid_in(vo8), .ser_data_in(do8), .ser_ready_out(ro8), .receiver_flush(flush48),
        .receiver_valid(rv8), .receiver_padding(rp8), .receiver_packet(rk8), .receiver_error(re8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full LANES=1 frame: latency, beat count, parity beat, ack handshake, flush
    task automatic send_l1(input logic [3:0] pad, input logic [41:0] pkt);
        int lat;
        int beats;
        pad1 = pad;
        pkt1 = pkt;
        en1  = 1'b1;
        tick();
        beats = int'(vo1);
        lat   = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            tick();
            if (k == 46) chk("l1_par_beat", {vo1, do1}, {1'b1, ^{pad, pkt}});
            if (vo1) beats++;
            if (rv1) lat = k;
        end
        chk("l1_latency", lat, 48);
        chk("l1_beats", beats, 47);
        chk("l1_rx_pad", rp1, pad);
        chk("l1_rx_pkt", rk1, pkt);
        chk("l1_ack", ack1, 1);
        beats = 0;
        repeat (5) begin
            tick();
            beats += int'(vo1);
        end
        chk("l1_no_resend", beats, 0);
        chk("l1_ack_held", ack1, 1);
        en1 = 1'b0;
        tick();
        chk("l1_ack_drop", ack1, 0);
        flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        chk("l1_flushed", rv1, 0);
    endtask

    initial begin
        int lat4, lat8, errk, nerr, cnt, i, c;
        logic vseen, rlow;
        logic [46:0] fr;

        rst = 1'b1; en1 = 1'b0; pad1 = '0; pkt1 = '0; flush1 = 1'b0;
        drv = 1'b0; drv_valid = 1'b0; drv_data = 1'b0; flip_en = 1'b0;
        en48 = 1'b0; pad48 = '0; pkt48 = '0; flush48 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_outs", {ack1, vo1, do1, rv1, re1, rp1, rk1}, 0);
        chk("rst_ready", {ro1, ro4, ro8}, 3'b111);

        // 1: LANES=1 frame
        send_l1(PAD_A, PKT_A);

        // 2: LANES=4 and 8, zero-filled last data beat
        pad48 = PAD_A;
        pkt48 = PKT_A;
        en48  = 1'b1;
        tick();
        chk("l4_beat0", {vo4, do4}, 5'h19);
        lat4 = 0;
        lat8 = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 5)  chk("l8_fill_beat", {vo8, do8}, 9'h12E);
            if (k == 6)  chk("l8_par_beat", {vo8, do8}, 9'h100);
            if (k == 7)  chk("l8_end", vo8, 0);
            if (k == 11) chk("l4_fill_beat", {vo4, do4}, 5'h12);
            if (k == 12) chk("l4_par_beat", {vo4, do4}, 5'h10);
            if (k == 13) chk("l4_end", vo4, 0);
            if (rv4 && lat4 == 0) lat4 = k;
            if (rv8 && lat8 == 0) lat8 = k;
        end
        chk("l4_latency", lat4, 14);
        chk("l8_latency", lat8, 8);
        chk("l4_rx", {rp4, rk4}, {PAD_A, PKT_A});
        chk("l8_rx", {rp8, rk8}, {PAD_A, PKT_A});
        chk("l48_ack", {ack4, ack8}, 2'b11);
        en48 = 1'b0;
        tick();
        flush48 = 1'b1;
        tick();
        flush48 = 1'b0;
        chk("l48_flushed", {rv4, rv8}, 0);

        // 3: bit flip on beat 5
        flip_en = 1'b1;
        pad1 = PAD_A;
        pkt1 = PKT_A;
        en1  = 1'b1;
        tick();
        errk = 0; nerr = 0; vseen = 1'b0; rlow = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (re1) begin
                nerr++;
                if (errk == 0) errk = k;
            end
            vseen |= rv1;
            rlow  |= !ro1;
        end
        chk("flip_err_at", errk, 48);
        chk("flip_err_len", nerr, 1);
        chk("flip_no_valid", vseen, 0);
        chk("flip_ready_low", rlow, 0);
        chk("flip_pkt_kept", rk1, PKT_A);
        en1 = 1'b0;
        tick();
        flip_en = 1'b0;

        // 4: backpressure while frame A is held
        en1 = 1'b1;
        tick();
        for (int k = 0; k < 60 && !rv1; k++) tick();
        chk("bp_a_valid", rv1, 1);
        en1 = 1'b0;
        tick();
        pad1 = PAD_B;
        pkt1 = PKT_B;
        en1  = 1'b1;
        cnt  = 0;
        repeat (10) begin
            tick();
            cnt += int'(vo1);
        end
        chk("bp_tx_stalled", cnt, 0);
        chk("bp_no_ack", ack1, 0);
        chk("bp_a_kept", {rp1, rk1}, {PAD_A, PKT_A});
        flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        for (int k = 0; k < 60 && !rv1; k++) tick();
        chk("bp_b_valid", rv1, 1);
        chk("bp_b_rx", {rp1, rk1}, {PAD_B, PKT_B});
        en1 = 1'b0;
        tick();
        flush1 = 1'b1;
        tick();
        flush1 = 1'b0;

        // 5: gapped reception, every third cycle idle
        fr  = {^{PAD_C, PKT_C}, PAD_C, PKT_C};
        drv = 1'b1;
        i = 0;
        c = 0;
        while (i < 47 && c < 200) begin
            drv_valid = (c % 3 != 2);
            if (drv_valid) begin
                drv_data = fr[i];
                i++;
            end else begin
                drv_data = 1'b0;
            end
            tick();
            c++;
        end
        drv_valid = 1'b0;
        for (int k = 0; k < 10 && !rv1; k++) tick();
        chk("gap_valid", rv1, 1);
        chk("gap_err", re1, 0);
        chk("gap_rx", {rp1, rk1}, {PAD_C, PKT_C});
        flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        drv = 1'b0;

        // 6: reset mid-SEND, then a fresh frame with odd parity
        pad1 = PAD_A;
        pkt1 = PKT_A;
        en1  = 1'b1;
        tick();
        repeat (10) tick();
        rst  = 1'b1;
        pad1 = PAD_C;
        pkt1 = PKT_C;
        tick();
        rst = 1'b0;
        chk("midrst_outs", {ack1, vo1, do1, rv1, re1, rp1, rk1}, 0);
        chk("midrst_ready", ro1, 1);
        send_l1(PAD_C, PKT_C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
